clk_gen_multi: RTL and testbench

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

---
 rtl/clk_gen_multi_if.sv | 30 +++
 rtl/clk_gen_multi.sv | 152 +++++++++++++++
 tb/tb_clk_gen_multi.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_gen_multi_if.sv
// Control/status bundle for the multi-channel clock generator.
// The master drives configuration and start/stop; the slave returns the generated clocks and status.
interface clk_gen_multi_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16,
  parameter int unsigned NW  = 8
);
  logic              start;
  logic              stop;
  logic [NCH-1:0]    ch_en;
  logic [NCH*CW-1:0] half_per;
  logic [NCH-1:0]    init_lvl;
  logic [NW-1:0]     limit;
  logic [NCH-1:0]    div_clk;
  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    parity;
  logic [NCH*NW-1:0] edge_cnt;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, ch_en, half_per, init_lvl, limit,
    input  div_clk, rise, parity, edge_cnt, busy, done
  );

  modport slave (
    input  start, stop, ch_en, half_per, init_lvl, limit,
    output div_clk, rise, parity, edge_cnt, busy, done
  );
endinterface

// File: rtl/clk_gen_multi.sv
// Multi-channel divided-clock generator: NCH independent 50% duty clocks, each with a
// programmable half-period, optional rising-edge limit, and a shared IDLE/RUN/DONE controller.
module clk_gen_multi #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16,
  parameter int unsigned NW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  clk_gen_multi_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  hp_q  [NCH];
  logic [NW-1:0]  ec_q  [NCH];
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] div_q;
  logic [NCH-1:0] rise_q;
  logic [NCH-1:0] par_q;
  logic [NW-1:0]  lim_q;
  logic           busy_q;
  logic           done_q;

  logic           start_ok_c;
  logic [NCH-1:0] frozen_c;
  logic           all_frozen_c;
  logic           load_c;
  logic           run_c;
  logic           busy_d;
  logic           done_d;

  // Stop dominates start; an empty channel mask never launches a run.
  assign start_ok_c = bus.start && !bus.stop && (|bus.ch_en);

  // A channel is finished once its edge count reaches a non-zero limit; idle channels count as finished.
  always_comb begin
    frozen_c = '0;
    for (int i = 0; i < NCH; i++) begin
      frozen_c[i] = !en_q[i] || ((lim_q != '0) && (ec_q[i] == lim_q));
    end
  end

  assign all_frozen_c = &frozen_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_ok_c) state_d = S_RUN;
      S_RUN: begin
        if (bus.stop)          state_d = S_IDLE;
        else if (all_frozen_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    load_c = 1'b0;
    run_c  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    load_c = (state_q == S_IDLE) && (state_d == S_RUN);
    run_c  = (state_q == S_RUN)  && (state_d == S_RUN);
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // Per-channel dividers; rise, parity and edge count update on the same edge as the 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        hp_q[i]  <= '0;
        ec_q[i]  <= '0;
      end
      en_q   <= '0;
      div_q  <= '0;
      rise_q <= '0;
      par_q  <= '0;
      lim_q  <= '0;
    end else if (load_c) begin
      for (int i = 0; i < NCH; i++) begin
        // A zero half-period behaves as one cycle.
        hp_q[i]  <= (bus.half_per[i*CW +: CW] == '0) ? CW'(1) : bus.half_per[i*CW +: CW];
        cnt_q[i] <= (bus.half_per[i*CW +: CW] == '0) ? CW'(1) : bus.half_per[i*CW +: CW];
        ec_q[i]  <= '0;
      end
      en_q   <= bus.ch_en;
      div_q  <= bus.ch_en & bus.init_lvl;
      rise_q <= '0;
      par_q  <= '0;
      lim_q  <= bus.limit;
    end else if (run_c) begin
      for (int i = 0; i < NCH; i++) begin
        if (frozen_c[i]) begin
          rise_q[i] <= 1'b0;
        end else if (cnt_q[i] == CW'(1)) begin
          cnt_q[i]  <= hp_q[i];
          div_q[i]  <= ~div_q[i];
          rise_q[i] <= ~div_q[i];
          if (!div_q[i]) begin
            par_q[i] <= ~par_q[i];
            ec_q[i]  <= ec_q[i] + NW'(1);
          end
        end else begin
          cnt_q[i]  <= cnt_q[i] - CW'(1);
          rise_q[i] <= 1'b0;
        end
      end
    end else begin
      // Outside RUN the clocks park low; counts and parity keep their last values.
      div_q  <= '0;
      rise_q <= '0;
    end
  end

  assign bus.div_clk = div_q;
  assign bus.rise    = rise_q;
  assign bus.parity  = par_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign bus.edge_cnt[g*NW +: NW] = ec_q[g];
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Scoreboard bench for clk_gen_multi: a closed-form per-cycle reference model pushes expected
// outputs on every edge; an independent monitor pops and compares on the falling edge.
module tb_clk_gen_multi;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned NW  = 8;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct packed {
    logic [NCH-1:0]    div;
    logic [NCH-1:0]    rise;
    logic [NCH-1:0]    par;
    logic [NCH*NW-1:0] ec;
    logic              busy;
    logic              done;
  } exp_t;

  logic clk;
  logic rst;

  clk_gen_multi_if #(.NCH(NCH), .CW(CW), .NW(NW)) bus ();

  clk_gen_multi #(.NCH(NCH), .CW(CW), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Reference model state
  int       m_mode = M_IDLE;
  int       m_t    = 0;
  bit [NCH-1:0] m_en;
  bit [NCH-1:0] m_init;
  int       m_hp  [NCH];
  int       m_lim = 0;
  int       m_ec  [NCH];
  bit [NCH-1:0] m_par;

  // Rising edges seen by time t: toggle k happens at t = k*h; rising toggles are the odd ones
  // when starting low and the even ones when starting high. Capped at a non-zero limit.
  function automatic int rises_at(bit init, int h, int lim, int t);
    int n;
    int c;
    n = t / h;
    c = init ? n / 2 : (n + 1) / 2;
    if (lim != 0 && c > lim) c = lim;
    return c;
  endfunction

  function automatic bit all_finished(int t);
    for (int i = 0; i < NCH; i++) begin
      if (m_en[i]) begin
        if (m_lim == 0) return 1'b0;
        if (rises_at(m_init[i], m_hp[i], m_lim, t) < m_lim) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Model: advance one clock edge from the sampled inputs and push the expected outputs.
  always @(posedge clk) begin
    exp_t e;
    int   c;
    int   cp;
    int   hv;
    e = '0;
    if (rst) begin
      m_mode = M_IDLE;
      for (int i = 0; i < NCH; i++) m_ec[i] = 0;
      m_par = '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (bus.start && !bus.stop && bus.ch_en != '0) begin
            m_en   = bus.ch_en;
            m_init = bus.init_lvl;
            m_lim  = int'(bus.limit);
            for (int i = 0; i < NCH; i++) begin
              hv = int'(bus.half_per[i*CW +: CW]);
              m_hp[i] = (hv == 0) ? 1 : hv;
            end
            m_t    = 0;
            m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (bus.stop)                m_mode = M_IDLE;
          else if (all_finished(m_t))  m_mode = M_DONE;
          else                         m_t    = m_t + 1;
        end
        default: m_mode = M_IDLE;
      endcase
    end

    if (m_mode == M_RUN) begin
      for (int i = 0; i < NCH; i++) begin
        if (m_en[i]) begin
          c = rises_at(m_init[i], m_hp[i], m_lim, m_t);
          cp = (m_t > 0) ? rises_at(m_init[i], m_hp[i], m_lim, m_t - 1) : 0;
          if (m_lim != 0 && c == m_lim) e.div[i] = 1'b1;
          else                          e.div[i] = m_init[i] ^ (((m_t / m_hp[i]) % 2) == 1);
          e.rise[i] = (m_t > 0) && (c > cp);
          m_ec[i]   = c % (1 << NW);
          m_par[i]  = (c % 2) == 1;
        end else begin
          m_ec[i]  = 0;
          m_par[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NCH; i++) e.ec[i*NW +: NW] = NW'(m_ec[i]);
    e.par  = m_par;
    e.busy = (m_mode == M_RUN);
    e.done = (m_mode == M_DONE);
    sb_q.push_back(e);
  end

  // Monitor: compare the DUT against the oldest expectation, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      vectors = vectors + 1;
      if (bus.div_clk !== e.div || bus.rise !== e.rise || bus.parity !== e.par ||
          bus.edge_cnt !== e.ec || bus.busy !== e.busy || bus.done !== e.done) begin
        miscompares = miscompares + 1;
        $display("FAIL outputs cyc=%0d got div=%b rise=%b par=%b ec=%h busy=%b done=%b required div=%b rise=%b par=%b ec=%h busy=%b done=%b",
                 cyc, bus.div_clk, bus.rise, bus.parity, bus.edge_cnt, bus.busy, bus.done,
                 e.div, e.rise, e.par, e.ec, e.busy, e.done);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    vectors = vectors + 1;
    if (bus.div_clk !== '0 || bus.rise !== '0 || bus.parity !== '0 ||
        bus.edge_cnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset state %s cyc=%0d got div=%b rise=%b par=%b ec=%h busy=%b done=%b required all 0",
               tag, cyc, bus.div_clk, bus.rise, bus.parity, bus.edge_cnt, bus.busy, bus.done);
    end
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      tick(1);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    vectors = vectors + 1;
    if (!seen) begin
      miscompares = miscompares + 1;
      $display("FAIL wait expired %s cyc=%0d: done not seen within %0d cycles", tag, cyc, max_cyc);
    end
  endtask

  task automatic cfg_start(input logic [NCH-1:0] en, input logic [NCH*CW-1:0] hp,
                           input logic [NCH-1:0] init, input logic [NW-1:0] lim);
    bus.ch_en    = en;
    bus.half_per = hp;
    bus.init_lvl = init;
    bus.limit    = lim;
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
  endtask

  function automatic logic [NCH*CW-1:0] hp_pack(input int h0, input int h1, input int h2, input int h3);
    logic [NCH*CW-1:0] v;
    v = '0;
    v[0*CW +: CW] = CW'(h0);
    v[1*CW +: CW] = CW'(h1);
    v[2*CW +: CW] = CW'(h2);
    v[3*CW +: CW] = CW'(h3);
    return v;
  endfunction

  task automatic rand_run();
    logic [NCH*CW-1:0] hp;
    logic [NCH-1:0]    en;
    logic [NW-1:0]     lim;
    int                n;
    en  = NCH'($urandom_range(0, 15));
    hp  = hp_pack($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    lim = ($urandom_range(0, 3) == 0) ? '0 : NW'($urandom_range(1, 6));
    cfg_start(en, hp, NCH'($urandom_range(0, 15)), lim);
    n = $urandom_range(5, 120);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 40) == 0) begin
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
      end else begin
        tick(1);
      end
    end
    if ($urandom_range(0, 1) == 1) pulse_stop();
    tick(3);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.ch_en    = '0;
    bus.half_per = '0;
    bus.init_lvl = '0;
    bus.limit    = '0;
    tick(3);
    check_reset_state("power-up");
    rst = 1'b0;
    tick(2);

    // Single free-running channel, starting high, half-period 5
    cfg_start(4'b0001, hp_pack(5, 0, 0, 0), 4'b0001, '0);
    tick(35);
    pulse_stop();
    tick(3);

    // Two channels with different periods and a shared limit of 21
    cfg_start(4'b0011, hp_pack(5, 3, 0, 0), 4'b0000, NW'(21));
    wait_done(215, "limit21");

    // Zero half-period counts as one; limit 4
    cfg_start(4'b0001, hp_pack(0, 0, 0, 0), 4'b0000, NW'(4));
    wait_done(12, "hp0_limit4");

    // Stop mid free-run, then start+stop together, then start with no channels
    cfg_start(4'b0001, hp_pack(5, 0, 0, 0), 4'b0000, '0);
    tick(36);
    pulse_stop();
    tick(4);
    bus.stop = 1'b1;
    cfg_start(4'b1111, hp_pack(2, 2, 2, 2), 4'b0000, '0);
    bus.stop = 1'b0;
    tick(4);
    cfg_start(4'b0000, hp_pack(2, 2, 2, 2), 4'b1111, '0);
    tick(4);

    // Reset in the middle of a run with start asserted
    cfg_start(4'b0101, hp_pack(4, 0, 6, 0), 4'b0100, '0);
    tick(48);
    rst       = 1'b1;
    bus.start = 1'b1;
    tick(1);
    rst       = 1'b0;
    bus.start = 1'b0;
    check_reset_state("mid-run");
    tick(4);

    // Edge counter wrap in free-run at half-period 1
    cfg_start(4'b0001, hp_pack(1, 0, 0, 0), 4'b0000, '0);
    tick(530);
    pulse_stop();
    tick(3);

    for (int r = 0; r < 30; r++) rand_run();

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
